// File: rtl/if_stage_if.sv
// Instruction-memory bus between the fetch stage and a combinational-read
// instruction memory.
interface if_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;

  modport master (output imem_addr, input imem_data);
  modport slave  (input imem_addr, output imem_data);
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and fetch
// counter, with branch redirect/flush resolved against the IF/ID instruction.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         branch,
  input  logic         zero,
  input  logic [31:0]  br_offset,
  if_stage_if.master   imem,
  output logic [31:0]  instr_id,
  output logic [31:0]  pc_plus4_id,
  output logic         valid_id,
  output logic [5:0]   op_id,
  output logic [5:0]   funct_id,
  output logic [31:0]  fetch_count
);

  logic [31:0] pc_q,    pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q,   pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] count_q, count_d;

  logic        taken;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  // A bubble in IF/ID can never redirect, whatever branch/zero say.
  assign taken    = branch & zero & valid_q;
  // Word offset to byte offset; the top two offset bits fall off the shift.
  assign target   = pc4_q + (br_offset << 2);
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    count_d = count_q;
    if (taken) begin
      pc_d    = target;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (!stall) begin
      pc_d    = pc_plus4;
      instr_d = imem.imem_data;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
      count_q <= 32'h0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign imem.imem_addr = pc_q;
  assign instr_id       = instr_q;
  assign pc_plus4_id    = pc4_q;
  assign valid_id       = valid_q;
  assign op_id          = instr_q[31:26];
  assign funct_id       = instr_q[5:0];
  assign fetch_count    = count_q;

endmodule
